// File: rtl/fetch_unit.sv
// 6502 instruction fetch stage: loads PC from the reset vector, then fetches
// opcode plus 0-2 operand bytes and presents them to the decoder with a level handshake.
module fetch_unit #(
    parameter int                    REG_WIDTH    = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [ADDR_WIDTH-1:0] operand_out,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_VEC_LO,
        S_VEC_HI,
        S_VEC_END,
        S_OP,
        S_OPC,
        S_LO,
        S_HI,
        S_READY
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = RESET_VECTOR + 1'b1;
    localparam logic [ADDR_WIDTH-1:0] ONE         = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [REG_WIDTH-1:0]   instr_q;
    logic [ADDR_WIDTH-1:0]  operand_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_q;
    logic                   illegal_q;
    logic                   ready_q;
    logic                   first_q;
    logic [1:0]             len_q;

    logic [ADDR_WIDTH-1:0]  pc_plus1;
    logic [1:0]             opc_len;

    // Instruction length from the aaa bbb cc opcode fields.
    function automatic logic [1:0] op_length(input logic [7:0] op);
        logic [2:0] aaa;
        logic [2:0] bbb;
        logic [1:0] cc;
        logic [1:0] len;
        aaa = op[7:5];
        bbb = op[4:2];
        cc  = op[1:0];
        len = 2'd1;
        case (cc)
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
                else                                                 len = 2'd2;
            end
            2'b00: begin
                if (op == 8'h20)
                    len = 2'd3;
                else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                    len = 2'd1;
                else begin
                    case (bbb)
                        3'b011, 3'b111:         len = 2'd3;
                        3'b000:                 len = (aaa >= 3'b101) ? 2'd2 : 2'd1;
                        3'b001, 3'b100, 3'b101: len = 2'd2;
                        default:                len = 2'd1;
                    endcase
                end
            end
            2'b10: begin
                case (bbb)
                    3'b011, 3'b111: len = 2'd3;
                    3'b000:         len = (aaa == 3'b101) ? 2'd2 : 2'd1;
                    3'b001, 3'b101: len = 2'd2;
                    default:        len = 2'd1;
                endcase
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

    assign pc_plus1 = pc_q + ONE;
    assign opc_len  = op_length(mem_rdata);

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            S_VEC_LO: begin
                mem_rd   = 1'b1;
                mem_addr = RESET_VECTOR;
            end
            S_VEC_HI: begin
                mem_rd   = 1'b1;
                mem_addr = VEC_HI_ADDR;
            end
            S_OP: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
            end
            S_OPC: begin
                if (opc_len > 2'd1) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_plus1;
                end
            end
            S_LO: begin
                if (len_q == 2'd3) begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_plus1;
                end
            end
            default: begin
                mem_rd   = 1'b0;
                mem_addr = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_VEC_LO;
            pc_q       <= '0;
            instr_q    <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
            illegal_q  <= 1'b0;
            ready_q    <= 1'b0;
            first_q    <= 1'b0;
            len_q      <= 2'd0;
        end else begin
            case (state_q)
                S_VEC_LO: state_q <= S_VEC_HI;
                S_VEC_HI: begin
                    pc_q[REG_WIDTH-1:0] <= mem_rdata;
                    state_q             <= S_VEC_END;
                end
                S_VEC_END: begin
                    pc_q[ADDR_WIDTH-1:REG_WIDTH] <= mem_rdata;
                    state_q                      <= S_OP;
                end
                S_OP: begin
                    instr_pc_q <= pc_q;
                    ready_q    <= 1'b0;
                    state_q    <= S_OPC;
                end
                S_OPC: begin
                    instr_q   <= mem_rdata;
                    illegal_q <= (mem_rdata[1:0] == 2'b11);
                    pc_q      <= pc_plus1;
                    len_q     <= opc_len;
                    if (opc_len > 2'd1) begin
                        state_q <= S_LO;
                    end else begin
                        operand_q <= '0;
                        ready_q   <= 1'b1;
                        first_q   <= 1'b1;
                        state_q   <= S_READY;
                    end
                end
                S_LO: begin
                    operand_q <= {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, mem_rdata};
                    pc_q      <= pc_plus1;
                    if (len_q == 2'd3) begin
                        state_q <= S_HI;
                    end else begin
                        ready_q <= 1'b1;
                        first_q <= 1'b1;
                        state_q <= S_READY;
                    end
                end
                S_HI: begin
                    operand_q[ADDR_WIDTH-1:REG_WIDTH] <= mem_rdata;
                    pc_q                              <= pc_plus1;
                    ready_q                           <= 1'b1;
                    first_q                           <= 1'b1;
                    state_q                           <= S_READY;
                end
                S_READY: begin
                    // The decoder drops done on our ready rising edge, so the
                    // first cycle's done is stale from the previous instruction.
                    first_q <= 1'b0;
                    if (!first_q && instruction_done) begin
                        if (pc_load) pc_q <= pc_in;
                        ready_q <= 1'b0;
                        state_q <= S_OP;
                    end
                end
                default: state_q <= S_VEC_LO;
            endcase
        end
    end

    assign instruction_out   = instr_q;
    assign operand_out       = operand_q;
    assign instruction_ready = ready_q;
    assign instr_pc          = instr_pc_q;
    assign pc_out            = pc_q;
    assign illegal           = illegal_q;

endmodule
